// File: rtl/mux_rr_pipe.sv
// mux_rr_pipe: N-to-1 data multiplexer with one registered output stage.
// The channel that may transfer (the candidate) comes from a fixed select
// index or from a round-robin search.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   in_data    CHANNELS*WIDTH packed input data; channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational)
//   mode       0 = fixed select by sel, 1 = round-robin
//   sel        channel index used in fixed mode
//   out_data   registered selected data
//   out_chan   registered index of the channel out_data came from
//   out_valid  registered output valid
//   out_ready  downstream ready
module mux_rr_pipe #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // One extra bit so CHANNELS itself is representable (e.g. 16 in 5 bits).
    localparam logic [SELW:0]   CH_L   = (SELW+1)'(CHANNELS);
    localparam logic [SELW-1:0] LAST_L = SELW'(CHANNELS - 1);

    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_chan_r;
    logic             out_valid_r;
    logic [SELW-1:0]  ptr_r;

    logic             accept_s;
    logic             rr_found_s;
    logic [SELW-1:0]  rr_idx_s;
    logic [SELW:0]    rr_probe_s;
    logic             rr_hit_s;
    logic             cand_found_s;
    logic [SELW-1:0]  cand_idx_s;
    logic [WIDTH-1:0] cand_data_s;
    logic             xfer_s;
    logic [SELW-1:0]  ptr_next_s;

    // The stage can take a word when it is empty or being drained this cycle.
    // During reset the stage is treated as accepting so in_ready stays
    // meaningful; whatever transfers in that cycle is dropped by the reset.
    assign accept_s = rst | ~out_valid_r | out_ready;

    // Round-robin search: first valid channel at ptr, ptr+1, ... modulo CHANNELS.
    // ptr_r is always below CHANNELS, so a single conditional subtract wraps.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = {SELW{1'b0}};
        rr_probe_s = {(SELW+1){1'b0}};
        rr_hit_s   = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            rr_probe_s = {1'b0, ptr_r} + k[SELW:0];
            rr_probe_s = (rr_probe_s >= CH_L) ? (rr_probe_s - CH_L) : rr_probe_s;
            rr_hit_s   = ~rr_found_s & in_valid[rr_probe_s[SELW-1:0]];
            rr_idx_s   = rr_hit_s ? rr_probe_s[SELW-1:0] : rr_idx_s;
            rr_found_s = rr_found_s | rr_hit_s;
        end
    end

    // Candidate selection. An out-of-range sel in fixed mode yields no
    // candidate, so nothing is granted and nothing transfers.
    always_comb begin
        cand_found_s = 1'b0;
        cand_idx_s   = {SELW{1'b0}};
        if (mode) begin
            cand_found_s = rr_found_s;
            cand_idx_s   = rr_idx_s;
        end else begin
            cand_found_s = ({1'b0, sel} < CH_L);
            cand_idx_s   = sel;
        end
    end

    // Grant only the candidate; in fixed mode this is independent of in_valid.
    always_comb begin
        in_ready = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = accept_s & cand_found_s & (cand_idx_s == i[SELW-1:0]);
        end
    end

    // Data mux gated by index match so only the candidate's data can be selected.
    always_comb begin
        cand_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            cand_data_s = (cand_idx_s == i[SELW-1:0]) ? in_data[i*WIDTH +: WIDTH] : cand_data_s;
        end
    end

    assign xfer_s     = accept_s & cand_found_s & in_valid[cand_idx_s];
    assign ptr_next_s = (cand_idx_s == LAST_L) ? {SELW{1'b0}} : (cand_idx_s + {{(SELW-1){1'b0}}, 1'b1});

    // Output stage: load on transfer, clear valid on a bare drain, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_chan_r  <= {SELW{1'b0}};
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= cand_data_s;
            out_chan_r  <= cand_idx_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Round-robin pointer advances past the granted channel; frozen in fixed mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {SELW{1'b0}};
        end else if (xfer_s && mode) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;
    assign out_valid = out_valid_r;

endmodule
